// File: rtl/fine_lock_pkg.sv
// Shared types and defaults for the fine-code lock detector.
package fine_lock_pkg;

   localparam int unsigned CodeWDef = 13;
   localparam int unsigned TolWDef  = 6;

   // Reset value of locked_code: mid-scale of the default code width
   localparam logic [CodeWDef-1:0] RstCodeDef = {1'b1, {(CodeWDef-1){1'b0}}};

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StAcq     = 2'd1,
      StLocked  = 2'd2,
      StIllegal = 2'd3
   } state_e;

endpackage

// File: rtl/code_sync_stable.sv
// Two-flop capture of an asynchronous bus; the output only takes a sample seen twice in a row.
module code_sync_stable #(
   parameter int unsigned WIDTH = 13
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [WIDTH-1:0] r_code;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_code <= '0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
         // A bus caught mid-transition will differ between stages; keep the old code then
         if (r_s1 == r_s2) begin
            r_code <= r_s2;
         end
      end
   end

   assign o_q = r_code;

endmodule

// File: rtl/fine_lock_detect.sv
// Windowed span detector declaring lock on a fine oscillator code.
// Optional lock-loss counter output enabled by defining FINE_LOCK_LOSS_CNT_EN.
module fine_lock_detect
   import fine_lock_pkg::*;
#(
   parameter int unsigned CODE_W = CodeWDef,
   parameter int unsigned TOL_W  = TolWDef
) (
   input  logic              ref_clk,
   input  logic              rst,
   input  logic              en,
   input  logic [CODE_W-1:0] osc_fine_con,
   input  logic [3:0]        win_len_log2,
   input  logic [TOL_W-1:0]  lock_tol,
   input  logic [TOL_W-1:0]  unlock_tol,
   input  logic [3:0]        lock_cnt_target,
   output logic              lock,
   output logic              lock_lost,
   output logic [CODE_W-1:0] locked_code,
   output logic [1:0]        state
`ifdef FINE_LOCK_LOSS_CNT_EN
   ,
   output logic [7:0]        lost_cnt
`endif
);

   localparam logic [CODE_W-1:0] RstCode = {1'b1, {(CODE_W-1){1'b0}}};

   state_e            r_state, w_state_nxt;
   logic [14:0]       r_win_cnt, w_win_cnt_nxt, w_term;
   logic              r_first, w_first_nxt;
   logic [3:0]        r_good_cnt, w_good_cnt_nxt, w_good_inc, w_target;
   logic [CODE_W-1:0] r_locked_code, w_locked_code_nxt;
   logic              r_lock_lost, w_lock_lost_nxt;
   logic [CODE_W-1:0] r_win_max, r_win_min;
   logic [CODE_W-1:0] w_code_q, w_cur_max, w_cur_min, w_span, w_mid;
   logic [CODE_W:0]   w_sum;
   logic [TOL_W-1:0]  w_unlock_lim;
   logic              w_close, w_good, w_lose;

   code_sync_stable #(
      .WIDTH (CODE_W)
   ) u_sync (
      .i_clk (ref_clk),
      .i_rst (rst),
      .i_d   (osc_fine_con),
      .o_q   (w_code_q)
   );

   // Terminal count follows win_len_log2 live; a larger count runs to the 15-bit wrap
   assign w_term  = 15'((16'd1 << win_len_log2) - 16'd1);
   assign w_close = (r_win_cnt == w_term);

   // Extremes include the current sample; r_first restarts them at a window boundary
   assign w_cur_max = (r_first || (w_code_q > r_win_max)) ? w_code_q : r_win_max;
   assign w_cur_min = (r_first || (w_code_q < r_win_min)) ? w_code_q : r_win_min;
   assign w_span    = w_cur_max - w_cur_min;
   assign w_sum     = {1'b0, w_cur_max} + {1'b0, w_cur_min};
   assign w_mid     = CODE_W'(w_sum >> 1);

   assign w_unlock_lim = (lock_tol > unlock_tol) ? lock_tol : unlock_tol;
   assign w_good       = (w_span <= CODE_W'(lock_tol));
   assign w_lose       = (w_span > CODE_W'(w_unlock_lim));
   assign w_target     = (lock_cnt_target == 4'd0) ? 4'd1 : lock_cnt_target;
   assign w_good_inc   = (r_good_cnt == 4'd15) ? 4'd15 : r_good_cnt + 4'd1;

   always_comb begin
      w_state_nxt       = r_state;
      w_win_cnt_nxt     = r_win_cnt;
      w_first_nxt       = r_first;
      w_good_cnt_nxt    = r_good_cnt;
      w_locked_code_nxt = r_locked_code;
      w_lock_lost_nxt   = 1'b0;
      if (!en) begin
         w_state_nxt = StIdle;
      end else begin
         unique case (r_state)
            StIdle: begin
               w_state_nxt    = StAcq;
               w_win_cnt_nxt  = '0;
               w_good_cnt_nxt = '0;
               w_first_nxt    = 1'b1;
            end
            StAcq: begin
               w_win_cnt_nxt = w_close ? 15'd0 : r_win_cnt + 15'd1;
               w_first_nxt   = w_close;
               if (w_close) begin
                  if (w_good) begin
                     w_good_cnt_nxt    = w_good_inc;
                     w_locked_code_nxt = w_mid;
                     if (w_good_inc >= w_target) begin
                        w_state_nxt = StLocked;
                     end
                  end else begin
                     w_good_cnt_nxt = '0;
                  end
               end
            end
            StLocked: begin
               w_win_cnt_nxt = w_close ? 15'd0 : r_win_cnt + 15'd1;
               w_first_nxt   = w_close;
               if (w_close) begin
                  if (w_lose) begin
                     w_state_nxt     = StAcq;
                     w_lock_lost_nxt = 1'b1;
                     w_good_cnt_nxt  = '0;
                  end else begin
                     w_locked_code_nxt = w_mid;
                  end
               end
            end
            default: begin
               w_state_nxt = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge ref_clk) begin
      if (rst) begin
         r_state       <= StIdle;
         r_win_cnt     <= '0;
         r_first       <= 1'b1;
         r_good_cnt    <= '0;
         r_locked_code <= RstCode;
         r_lock_lost   <= 1'b0;
         r_win_max     <= '0;
         r_win_min     <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_win_cnt     <= w_win_cnt_nxt;
         r_first       <= w_first_nxt;
         r_good_cnt    <= w_good_cnt_nxt;
         r_locked_code <= w_locked_code_nxt;
         r_lock_lost   <= w_lock_lost_nxt;
         r_win_max     <= w_cur_max;
         r_win_min     <= w_cur_min;
      end
   end

   assign lock        = (r_state == StLocked);
   assign lock_lost   = r_lock_lost;
   assign locked_code = r_locked_code;
   assign state       = r_state;

`ifdef FINE_LOCK_LOSS_CNT_EN
   logic [7:0] r_lost_cnt;

   always_ff @(posedge ref_clk) begin
      if (rst) begin
         r_lost_cnt <= '0;
      end else if (w_lock_lost_nxt && (r_lost_cnt != 8'hFF)) begin
         r_lost_cnt <= r_lost_cnt + 8'd1;
      end
   end

   assign lost_cnt = r_lost_cnt;
`endif

endmodule

// File: tb/tb_fine_lock_detect.sv
// Directed checks of fine_lock_detect; loss-counter steps build only with FINE_LOCK_LOSS_CNT_EN.
module tb_fine_lock_detect;
   import fine_lock_pkg::*;

   logic        ref_clk;
   logic        rst;
   logic        en;
   logic [12:0] osc;
   logic [3:0]  log2;
   logic [5:0]  lock_tol;
   logic [5:0]  unlock_tol;
   logic [3:0]  target;
   logic        lock;
   logic        lock_lost;
   logic [12:0] locked_code;
   logic [1:0]  state;
`ifdef FINE_LOCK_LOSS_CNT_EN
   logic [7:0]  lost_cnt;
`endif

   int checks = 0;
   int errors = 0;

   fine_lock_detect #(
      .CODE_W (13),
      .TOL_W  (6)
   ) dut (
      .ref_clk         (ref_clk),
      .rst             (rst),
      .en              (en),
      .osc_fine_con    (osc),
      .win_len_log2    (log2),
      .lock_tol        (lock_tol),
      .unlock_tol      (unlock_tol),
      .lock_cnt_target (target),
      .lock            (lock),
      .lock_lost       (lock_lost),
      .locked_code     (locked_code),
      .state           (state)
`ifdef FINE_LOCK_LOSS_CNT_EN
      ,
      .lost_cnt        (lost_cnt)
`endif
   );

   initial ref_clk = 1'b0;
   always #5 ref_clk = ~ref_clk;

   task automatic tick();
      @(posedge ref_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reset, then idle with en=0 long enough for the sync stages to hold c
   task automatic restart(input logic [12:0] c);
      rst = 1'b1;
      en  = 1'b0;
      osc = c;
      tick();
      tick();
      rst = 1'b0;
      repeat (4) tick();
   endtask

   // Each value is held two cycles so the stability filter accepts it
   task automatic run_toggle(input logic [12:0] a, input logic [12:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         if ((i % 2) == 0) osc = (((i / 2) % 2) == 0) ? b : a;
         tick();
      end
   endtask

   initial begin
      rst        = 1'b1;
      en         = 1'b0;
      osc        = 13'h1000;
      log2       = 4'd4;
      lock_tol   = 6'd2;
      unlock_tol = 6'd8;
      target     = 4'd3;
      tick();
      tick();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_lock", 32'(lock), 32'd0);
      chk("rst_lock_lost", 32'(lock_lost), 32'd0);
      chk("rst_locked_code", 32'(locked_code), 32'(RstCodeDef));

      // Constant code: lock one cycle after the third 16-cycle window close
      restart(13'h1000);
      en = 1'b1;
      repeat (48) tick();
      chk("const_pre_state", 32'(state), 32'd1);
      chk("const_pre_lock", 32'(lock), 32'd0);
      tick();
      chk("const_lock", 32'(lock), 32'd1);
      chk("const_state", 32'(state), 32'd2);
      chk("const_code", 32'(locked_code), 32'h1000);

      // Span 16 > max(2,8) inside the next window -> loss at its close
      run_toggle(13'h1000, 13'h1010, 15);
      chk("loss_pre_lock", 32'(lock), 32'd1);
      tick();
      chk("loss_lock", 32'(lock), 32'd0);
      chk("loss_pulse", 32'(lock_lost), 32'd1);
      chk("loss_state", 32'(state), 32'd1);
      tick();
      chk("loss_pulse_end", 32'(lock_lost), 32'd0);
      chk("loss_code_hold", 32'(locked_code), 32'h1000);

      // Span exactly lock_tol locks; span one above never does
      restart(13'h0FFF);
      en = 1'b1;
      run_toggle(13'h0FFF, 13'h1001, 48);
      chk("span2_pre_lock", 32'(lock), 32'd0);
      tick();
      chk("span2_lock", 32'(lock), 32'd1);
      chk("span2_code", 32'(locked_code), 32'h1000);
      restart(13'h0FFF);
      en = 1'b1;
      run_toggle(13'h0FFF, 13'h1002, 64);
      chk("span3_lock", 32'(lock), 32'd0);
      chk("span3_state", 32'(state), 32'd1);

      // Target 0 acts as 1; midpoint (0x123+0x124)>>1 truncates to 0x123
      target = 4'd0;
      restart(13'h0123);
      en = 1'b1;
      run_toggle(13'h0123, 13'h0124, 16);
      chk("t0_pre_lock", 32'(lock), 32'd0);
      tick();
      chk("t0_lock", 32'(lock), 32'd1);
      chk("mid_trunc", 32'(locked_code), 32'h0123);

      // Drop en mid-window while locked
      repeat (3) tick();
      en = 1'b0;
      tick();
      chk("en0_state", 32'(state), 32'd0);
      chk("en0_lock", 32'(lock), 32'd0);
      chk("en0_lock_lost", 32'(lock_lost), 32'd0);
      chk("en0_code_hold", 32'(locked_code), 32'h0123);

      // Code never stable: code_q keeps 0x400, window span stays 0
      target = 4'd1;
      restart(13'h0400);
      en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         osc = 13'h0800 + 13'(i * 17);
         tick();
      end
      chk("unstable_pre_lock", 32'(lock), 32'd0);
      osc = 13'h0A00;
      tick();
      chk("unstable_lock", 32'(lock), 32'd1);
      chk("unstable_code", 32'(locked_code), 32'h0400);

      // One-cycle windows: three consecutive closes
      target = 4'd3;
      log2   = 4'd0;
      restart(13'h0555);
      en = 1'b1;
      repeat (3) tick();
      chk("w1_pre_lock", 32'(lock), 32'd0);
      tick();
      chk("w1_lock", 32'(lock), 32'd1);
      chk("w1_code", 32'(locked_code), 32'h0555);

      // Shrink window length mid-window: closes at count 3 instead of 15
      target = 4'd1;
      log2   = 4'd4;
      restart(13'h0AAA);
      en = 1'b1;
      tick();
      log2 = 4'd2;
      repeat (3) tick();
      chk("shrink_pre_lock", 32'(lock), 32'd0);
      chk("shrink_pre_state", 32'(state), 32'd1);
      tick();
      chk("shrink_lock", 32'(lock), 32'd1);
      chk("shrink_code", 32'(locked_code), 32'h0AAA);

      // rst wins over en
      rst = 1'b1;
      tick();
      chk("rstpri_state", 32'(state), 32'd0);
      chk("rstpri_lock", 32'(lock), 32'd0);
      chk("rstpri_code", 32'(locked_code), 32'h1000);
      rst = 1'b0;

`ifdef FINE_LOCK_LOSS_CNT_EN
      // Alternate lock_tol between 63 and 0 to force one loss per iteration
      log2       = 4'd2;
      target     = 4'd1;
      unlock_tol = 6'd0;
      lock_tol   = 6'd63;
      restart(13'h0100);
      en = 1'b1;
      for (int k = 0; k < 300; k++) begin
         lock_tol = 6'd63;
         run_toggle(13'h0100, 13'h0110, 8);
         lock_tol = 6'd0;
         run_toggle(13'h0100, 13'h0110, 8);
      end
      chk("lost_cnt_sat", 32'(lost_cnt), 32'd255);
      rst = 1'b1;
      tick();
      chk("lost_cnt_rst", 32'(lost_cnt), 32'd0);
      rst = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
